serial_pattern_tx: RTL and testbench

Serial pattern transmitter that drives the single-bit stream consumed by `mealy_machine`, our serial sequence detector. It accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts each word out one bit per clock. An optional idle gap separates consecutive words. It stimulates the detector on-chip and forms the transmit end of the serial link whose receive end is the detector.

---
 rtl/serial_pattern_tx.sv | 197 +++++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx
//  Brief    : Parallel-in, serial-out pattern transmitter. Words are accepted
//             over a valid/ready handshake into a small FIFO, then shifted out
//             one bit per clock, with an optional idle gap after each word.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter int   GAP       = 0,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_BW = $clog2(WIDTH);
  localparam int c_GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  // Serializer state
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [c_BW-1:0]  r_bit_cnt;
  logic [c_GW-1:0]  r_gap_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_head_first;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shreg_adv;
  logic             w_last_bit;
  logic             w_gap_done;

  assign w_full     = (r_count == c_CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // Ready is derived from the registered count only, so a pop on the same
  // edge never lets a push into a full FIFO.
  assign data_ready = !w_full && !reset;
  assign w_push     = data_valid && data_ready;
  assign busy       = !reset && ((r_state != S_IDLE) || !w_empty);

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_first = (LSB_FIRST != 0) ? w_head[0] : w_head[WIDTH-1];
  // The bit currently on 'out' sits at the shifted-out end of r_shreg, so the
  // next bit is its neighbour.
  assign w_next_bit   = (LSB_FIRST != 0) ? r_shreg[1] : r_shreg[WIDTH-2];
  assign w_shreg_adv  = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);
  assign w_last_bit   = (r_bit_cnt == c_BW'(WIDTH-1));
  assign w_gap_done   = (r_gap_cnt == c_GW'(GAP-1));

  // Decide whether the serializer takes the FIFO head on this edge
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = !w_empty;
      S_SHIFT: w_pop = w_last_bit && (GAP == 0) && !w_empty;
      S_GAP:   w_pop = w_gap_done && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // FIFO data array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer FSM with registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      out       <= IDLE_BIT;
      out_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_SHIFT;
            r_shreg   <= w_head;
            r_bit_cnt <= '0;
            out       <= w_head_first;
            out_valid <= 1'b1;
            word_done <= 1'b0;
          end else begin
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            word_done <= 1'b0;
          end
        end

        S_SHIFT: begin
          if (!w_last_bit) begin
            r_shreg   <= w_shreg_adv;
            r_bit_cnt <= r_bit_cnt + c_BW'(1);
            out       <= w_next_bit;
            out_valid <= 1'b1;
            word_done <= (r_bit_cnt == c_BW'(WIDTH-2));
          end else if (GAP > 0) begin
            r_state   <= S_GAP;
            r_gap_cnt <= '0;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            word_done <= 1'b0;
          end else if (w_pop) begin
            // Back-to-back: next word's first bit follows the last bit directly
            r_shreg   <= w_head;
            r_bit_cnt <= '0;
            out       <= w_head_first;
            out_valid <= 1'b1;
            word_done <= 1'b0;
          end else begin
            r_state   <= S_IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            word_done <= 1'b0;
          end
        end

        S_GAP: begin
          if (!w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + c_GW'(1);
          end else if (w_pop) begin
            r_state   <= S_SHIFT;
            r_shreg   <= w_head;
            r_bit_cnt <= '0;
            out       <= w_head_first;
            out_valid <= 1'b1;
            word_done <= 1'b0;
          end else begin
            r_state   <= S_IDLE;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            word_done <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          out       <= IDLE_BIT;
          out_valid <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_pattern_tx
//  Brief    : Scoreboard bench for serial_pattern_tx. Two instances: GAP=0
//             and GAP=2. Accepted words push expected {bit, word_done} pairs
//             into per-instance queues; negedge monitors pop and compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0_in, d2_in;
  logic       d0_v, d2_v;
  logic       d0_rdy, d0_out, d0_ov, d0_wd, d0_busy;
  logic       d2_rdy, d2_out, d2_ov, d2_wd, d2_busy;

  int tests = 0;
  int fails = 0;
  logic [1:0] q0[$];
  logic [1:0] q2[$];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .DEPTH(4), .GAP(0), .LSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(d0_in), .data_valid(d0_v), .data_ready(d0_rdy),
    .out(d0_out), .out_valid(d0_ov), .word_done(d0_wd), .busy(d0_busy)
  );

  serial_pattern_tx #(.WIDTH(8), .DEPTH(4), .GAP(2), .LSB_FIRST(0), .IDLE_BIT(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(d2_in), .data_valid(d2_v), .data_ready(d2_rdy),
    .out(d2_out), .out_valid(d2_ov), .word_done(d2_wd), .busy(d2_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the GAP=0 instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (d0_ov) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut0 unexpected bit: got out=%0b expected no valid bit (t=%0t)", d0_out, $time);
        end else begin
          e = q0.pop_front();
          chk("dut0 bit/word_done", {d0_out, d0_wd}, e);
        end
      end else begin
        chk("dut0 idle out/word_done", {d0_out, d0_wd}, 2'b00);
      end
    end
  end

  // Monitor for the GAP=2 instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      if (d2_ov) begin
        if (q2.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut2 unexpected bit: got out=%0b expected no valid bit (t=%0t)", d2_out, $time);
        end else begin
          e = q2.pop_front();
          chk("dut2 bit/word_done", {d2_out, d2_wd}, e);
        end
      end else begin
        chk("dut2 idle out/word_done", {d2_out, d2_wd}, 2'b00);
      end
    end
  end

  // Offer one word at a negedge, hold it until accepted, queue its bits
  task automatic push(input int sel, input logic [7:0] w, output logic saw_full);
    int n;
    saw_full = 1'b0;
    if (sel == 0) begin d0_in = w; d0_v = 1'b1; end
    else          begin d2_in = w; d2_v = 1'b1; end
    n = 0;
    while (!((sel == 0) ? d0_rdy : d2_rdy) && n < 50) begin
      saw_full = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL push timeout: got data_ready=0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
      for (int i = 7; i >= 0; i--) begin
        if (sel == 0) q0.push_back({w[i], (i == 0)});
        else          q2.push_back({w[i], (i == 0)});
      end
      @(negedge clk);
    end
    if (sel == 0) d0_v = 1'b0;
    else          d2_v = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("dut0 drain queue size", q0.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sf;
    logic any_full;
    reset = 1'b1;
    d0_in = '0; d2_in = '0; d0_v = 1'b0; d2_v = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset out",        {d0_out, d2_out}, 2'b00);
    chk("reset out_valid",  {d0_ov, d2_ov},   2'b00);
    chk("reset data_ready", {d0_rdy, d2_rdy}, 2'b00);
    chk("reset busy",       {d0_busy, d2_busy}, 2'b00);
    chk("reset word_done",  {d0_wd, d2_wd},   2'b00);
    reset = 1'b0;
    #1;
    chk("ready after release", {d0_rdy, d2_rdy}, 2'b11);

    // Single word A5, MSB first, latency of 2 edges
    push(0, 8'hA5, sf);
    chk("latency: invalid after accept edge", d0_ov, 1'b0);
    @(negedge clk);
    chk("latency: valid after next edge", d0_ov, 1'b1);
    chk("latency: first bit of A5", d0_out, 1'b1);
    repeat (10) @(negedge clk);
    chk("A5 idle out_valid", d0_ov, 1'b0);
    chk("A5 idle busy", d0_busy, 1'b0);
    chk("A5 queue empty", q0.size(), 0);

    // Back-to-back, GAP=0: 16 contiguous valid bits
    push(0, 8'hAA, sf);
    push(0, 8'h0F, sf);
    for (int i = 0; i < 16; i++) begin
      chk("b2b contiguous valid", d0_ov, 1'b1);
      @(negedge clk);
    end
    chk("b2b valid drops after 16", d0_ov, 1'b0);

    // GAP=2: FF, two idle cycles, 00
    push(2, 8'hFF, sf);
    push(2, 8'h00, sf);
    for (int i = 0; i < 18; i++) begin
      chk("gap valid pattern", d2_ov, (i < 8 || i >= 10) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    chk("gap valid drops after word 2", d2_ov, 1'b0);
    repeat (3) @(negedge clk);
    chk("gap busy idle", d2_busy, 1'b0);
    chk("gap queue empty", q2.size(), 0);

    // Alternating pattern for the detector
    push(0, 8'h55, sf);
    drain0();

    // FIFO full with data_valid held: six words, ready must drop, order kept
    any_full = 1'b0;
    push(0, 8'h01, sf); any_full |= sf;
    push(0, 8'h23, sf); any_full |= sf;
    push(0, 8'h45, sf); any_full |= sf;
    push(0, 8'h67, sf); any_full |= sf;
    push(0, 8'h89, sf); any_full |= sf;
    push(0, 8'hAB, sf); any_full |= sf;
    chk("fifo full back-pressure seen", any_full, 1'b1);
    drain0();
    repeat (2) @(negedge clk);
    chk("fifo full busy after drain", d0_busy, 1'b0);

    // Reset during the third bit of the first of three queued words
    push(0, 8'hC3, sf);
    push(0, 8'h3C, sf);
    push(0, 8'hE7, sf);
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("midreset out_valid", d0_ov, 1'b0);
    chk("midreset data_ready", d0_rdy, 1'b0);
    chk("midreset busy", d0_busy, 1'b0);
    chk("midreset out", d0_out, 1'b0);
    reset = 1'b0;
    #1;
    chk("midreset ready after release", d0_rdy, 1'b1);
    repeat (20) @(negedge clk);
    chk("midreset no resume out_valid", d0_ov, 1'b0);
    chk("midreset no resume busy", d0_busy, 1'b0);

    // New push after the flush works normally
    push(0, 8'h81, sf);
    drain0();

    repeat (3) @(negedge clk);
    chk("final q0 empty", q0.size(), 0);
    chk("final q2 empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
